// File: rtl/ysyx_22040931_mem_stage.sv
// MEM stage: takes EX bundles, runs one load/store on a single-outstanding data bus, hands a registered bundle to WB.
// Non-memory ops reach WB one cycle after accept; EX is stalled while an access is in flight or WB is holding off.
module ysyx_22040931_mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              to_ex_ready,
  input  logic              w_ena_i,
  input  logic [4:0]        w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic              mem_ena_i,
  input  logic              mem_wr_i,
  input  logic [2:0]        memrop_i,
  input  logic [2:0]        memwop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [63:0]       pc_i,
  input  logic [31:0]       instr_i,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [DATA_W-1:0] dbus_wdata,
  output logic [DATA_W/8-1:0] dbus_wstrb,
  input  logic              dbus_gnt,
  input  logic              dbus_rvalid,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              w_ena,
  output logic [4:0]        w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic [63:0]       pc_o,
  output logic [31:0]       instr_o
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t             state;
  logic [2:0]         rop;
  logic [OFF_W-1:0]   off;
  logic               is_load;
  logic               accept;
  logic [LANES-1:0]   strb_base;
  logic [DATA_W-1:0]  lane;
  logic [DATA_W-1:0]  load_data;

  assign to_ex_ready = ~reset & ((state == IDLE) | ((state == OUT) & wb_ready));
  assign accept      = ex_valid & to_ex_ready;
  assign wb_valid    = (state == OUT);

  always_comb begin
    strb_base = '0;
    case (memwop_i)
      3'd0:    strb_base = LANES'(1);
      3'd1:    strb_base = LANES'(3);
      3'd2:    strb_base = LANES'(15);
      3'd3:    strb_base = '1;
      default: strb_base = '0;
    endcase
  end

  // Lanes shifted in from above byte 7 are zero, so misaligned loads simply lose the upper bytes.
  always_comb begin
    lane      = dbus_rdata >> {off, 3'b000};
    load_data = '0;
    case (rop)
      3'd0:    load_data = {{(DATA_W-8){lane[7]}},   lane[7:0]};
      3'd1:    load_data = {{(DATA_W-16){lane[15]}}, lane[15:0]};
      3'd2:    load_data = {{(DATA_W-32){lane[31]}}, lane[31:0]};
      3'd3:    load_data = lane;
      3'd4:    load_data = {{(DATA_W-8){1'b0}},  lane[7:0]};
      3'd5:    load_data = {{(DATA_W-16){1'b0}}, lane[15:0]};
      3'd6:    load_data = {{(DATA_W-32){1'b0}}, lane[31:0]};
      default: load_data = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rop        <= '0;
      off        <= '0;
      is_load    <= 1'b0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_wdata <= '0;
      dbus_wstrb <= '0;
      w_ena      <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      pc_o       <= '0;
      instr_o    <= '0;
    end else begin
      case (state)
        REQ: if (dbus_gnt) begin
          dbus_req <= 1'b0;
          state    <= WAIT;
        end
        WAIT: if (dbus_rvalid) begin
          state <= OUT;
          if (is_load) w_data <= load_data;
        end
        OUT: if (wb_ready && !accept) state <= IDLE;
        default: ;
      endcase

      // Accepts only happen in IDLE/OUT, so this never races the REQ/WAIT arms above.
      if (accept) begin
        state    <= mem_ena_i ? REQ : OUT;
        dbus_req <= mem_ena_i;
        w_ena    <= w_ena_i;
        w_addr   <= w_addr_i;
        w_data   <= w_data_i;
        pc_o     <= pc_i;
        instr_o  <= instr_i;
        rop      <= memrop_i;
        off      <= mem_addr_i[OFF_W-1:0];
        is_load  <= mem_ena_i & ~mem_wr_i;
        if (mem_ena_i) begin
          dbus_we    <= mem_wr_i;
          dbus_addr  <= {mem_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
          dbus_wdata <= mem_data_i << {mem_addr_i[OFF_W-1:0], 3'b000};
          dbus_wstrb <= mem_wr_i ? (strb_base << mem_addr_i[OFF_W-1:0]) : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040931_mem_stage.sv
// Bench for the MEM stage: directed corner cases, then random traffic against a byte-array memory model.
module tb_ysyx_22040931_mem_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0, to_ex_ready;
  logic        w_ena_i = 1'b0;
  logic [4:0]  w_addr_i = '0;
  logic [63:0] w_data_i = '0;
  logic        mem_ena_i = 1'b0, mem_wr_i = 1'b0;
  logic [2:0]  memrop_i = '0, memwop_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [63:0] mem_data_i = '0, pc_i = '0;
  logic [31:0] instr_i = '0;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [63:0] dbus_wdata;
  logic [7:0]  dbus_wstrb;
  logic        dbus_gnt = 1'b0, dbus_rvalid = 1'b0;
  logic [63:0] dbus_rdata = '0;
  logic        wb_valid, wb_ready = 1'b1;
  logic        w_ena;
  logic [4:0]  w_addr;
  logic [63:0] w_data, pc_o;
  logic [31:0] instr_o;

  always #5 clock = ~clock;

  ysyx_22040931_mem_stage #(.ADDR_W(32), .DATA_W(64)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .to_ex_ready(to_ex_ready),
    .w_ena_i(w_ena_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .mem_ena_i(mem_ena_i), .mem_wr_i(mem_wr_i), .memrop_i(memrop_i), .memwop_i(memwop_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .pc_i(pc_i), .instr_i(instr_i),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_wstrb(dbus_wstrb), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
    .pc_o(pc_o), .instr_o(instr_o)
  );

  typedef struct {
    logic w_ena; logic [4:0] w_addr; logic [63:0] w_data; logic [63:0] pc; logic [31:0] instr;
    logic mem; logic wr; logic [2:0] rop; logic [2:0] wop; logic [31:0] addr; logic [63:0] sdata;
  } tx_t;
  typedef struct { logic [63:0] w_data; logic [63:0] pc; logic [37:0] misc; } wb_t;
  typedef struct { logic we; logic [31:0] addr; logic [63:0] wdata; logic [7:0] wstrb; } bus_t;

  int n_vec = 0, n_bad = 0;
  tx_t  drv_tx;
  bit   drv_have = 0;
  wb_t  exp_q[$];
  bus_t bus_q[$];
  logic [7:0]  ref_mem [0:63];
  logic [63:0] bmem [0:7];
  int   rsp_state = 0, rsp_cnt = 0, gnt_dly = 0, rv_dly = 0;
  logic [2:0] rsp_idx = '0;
  bit   ready_rand = 0, rv_inject = 0, prev_hold = 0;
  logic ready_force = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sz(input logic [2:0] code);
    case (code)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      3'd3:       return 8;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [63:0] ref_load(input logic [31:0] a, input logic [2:0] code);
    int off, base, n;
    logic [63:0] v;
    off = int'(a[2:0]); base = int'(a[5:3]) * 8; n = sz(code); v = '0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) v |= 64'(ref_mem[base + off + i]) << (8 * i);
    if (code < 3'd3 && v[8*n-1]) v |= ~64'd0 << (8 * n);
    return v;
  endfunction

  task automatic set_word(input int idx, input logic [63:0] val);
    bmem[idx] = val;
    for (int b = 0; b < 8; b++) ref_mem[idx*8 + b] = val[8*b +: 8];
  endtask

  task automatic model_accept(input tx_t t);
    wb_t  e;
    bus_t b;
    int off, base, n;
    off = int'(t.addr[2:0]); base = int'(t.addr[5:3]) * 8;
    e.pc = t.pc; e.misc = {t.instr, t.w_ena, t.w_addr}; e.w_data = t.w_data;
    if (t.mem) begin
      b.we = t.wr; b.addr = {t.addr[31:3], 3'b000}; b.wstrb = '0;
      b.wdata = t.sdata << (8 * off);
      if (t.wr) begin
        n = sz(t.wop);
        for (int i = 0; i < n; i++)
          if (off + i < 8) begin
            b.wstrb[off + i] = 1'b1;
            ref_mem[base + off + i] = t.sdata[8*i +: 8];
          end
      end else e.w_data = ref_load(t.addr, t.rop);
      bus_q.push_back(b);
    end
    exp_q.push_back(e);
  endtask

  function automatic tx_t mk(input logic mem, input logic wr, input logic [2:0] rop, input logic [2:0] wop,
                             input logic [31:0] addr, input logic [63:0] sdata, input logic [63:0] wdata);
    tx_t t;
    t.w_ena = 1'b1; t.w_addr = 5'd7; t.w_data = wdata; t.pc = 64'h8000_1000; t.instr = 32'h0000_3003;
    t.mem = mem; t.wr = wr; t.rop = rop; t.wop = wop; t.addr = addr; t.sdata = sdata;
    return t;
  endfunction

  function automatic tx_t rand_tx();
    tx_t t;
    logic [31:0] r;
    r = $urandom;
    t.w_ena = r[0]; t.w_addr = r[5:1]; t.wr = r[6]; t.rop = r[9:7]; t.wop = r[11:10];
    t.mem = (r[13:12] != 2'b00);
    t.addr = 32'h8000_0000 | 32'($urandom_range(0, 63));
    t.w_data = {$urandom, $urandom}; t.pc = {$urandom, $urandom}; t.instr = $urandom;
    t.sdata = {$urandom, $urandom};
    return t;
  endfunction

  task automatic step();
    wb_t  e;
    bus_t b;
    @(negedge clock);
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = {$urandom, $urandom};
    if (rsp_state == 0 && dbus_req) begin
      rsp_state = 1;
      rsp_cnt = (gnt_dly < 0) ? $urandom_range(0, 3) : gnt_dly;
    end
    if (rsp_state == 1) begin
      if (rsp_cnt == 0) dbus_gnt = 1'b1; else rsp_cnt--;
    end else if (rsp_state == 2) begin
      if (rsp_cnt == 0) begin dbus_rvalid = 1'b1; dbus_rdata = bmem[rsp_idx]; end
      else rsp_cnt--;
    end
    if (rv_inject) begin dbus_rvalid = 1'b1; rv_inject = 0; end
    ex_valid = drv_have;
    w_ena_i = drv_tx.w_ena; w_addr_i = drv_tx.w_addr; w_data_i = drv_tx.w_data;
    mem_ena_i = drv_tx.mem; mem_wr_i = drv_tx.wr; memrop_i = drv_tx.rop; memwop_i = drv_tx.wop;
    mem_addr_i = drv_tx.addr; mem_data_i = drv_tx.sdata; pc_i = drv_tx.pc; instr_i = drv_tx.instr;
    wb_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
    #1;
    if (prev_hold) chk("wb_hold", 64'(wb_valid), 64'd1);
    prev_hold = wb_valid & ~wb_ready;
    if (rsp_state != 0) chk("ex_rdy_busy", 64'(to_ex_ready), 64'd0);
    if (dbus_gnt) begin
      if (bus_q.size() == 0) chk("gnt_unexpected", 64'd1, 64'd0);
      else begin
        b = bus_q.pop_front();
        chk("dbus_addr", 64'(dbus_addr), 64'(b.addr));
        chk("dbus_we", 64'(dbus_we), 64'(b.we));
        if (b.we) begin
          chk("dbus_wstrb", 64'(dbus_wstrb), 64'(b.wstrb));
          chk("dbus_wdata", dbus_wdata, b.wdata);
          for (int i = 0; i < 8; i++)
            if (dbus_wstrb[i]) bmem[dbus_addr[5:3]][8*i +: 8] = dbus_wdata[8*i +: 8];
        end
      end
      rsp_idx = dbus_addr[5:3];
      rsp_state = 2;
      rsp_cnt = (rv_dly < 0) ? $urandom_range(0, 3) : rv_dly;
    end
    if (dbus_rvalid) rsp_state = 0;
    if (wb_valid && wb_ready) begin
      if (exp_q.size() == 0) chk("wb_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("wb_wdata", w_data, e.w_data);
        chk("wb_pc", pc_o, e.pc);
        chk("wb_misc", 64'({instr_o, w_ena, w_addr}), 64'(e.misc));
      end
    end
    if (ex_valid && to_ex_ready) begin
      model_accept(drv_tx);
      drv_have = 0;
    end
  endtask

  task automatic wait_wb(input string tag);
    int i;
    i = 0;
    while (!wb_valid && i < 40) begin step(); i++; end
    chk(tag, 64'(wb_valid), 64'd1);
  endtask

  initial begin
    int req_cnt, ntx, cyc;
    logic [31:0] saw_addr;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
    for (int w = 0; w < 8; w++)
      for (int b = 0; b < 8; b++) bmem[w][8*b +: 8] = ref_mem[w*8 + b];
    drv_tx = mk(1'b0, 1'b0, 3'd0, 3'd0, 32'h8000_0000, 64'd0, 64'd0);

    @(negedge clock); #1;
    chk("rst_to_ex_ready", 64'(to_ex_ready), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_dbus_req", 64'(dbus_req), 64'd0);
    chk("rst_w_data", w_data, 64'd0);
    chk("rst_misc", 64'({dbus_wstrb, w_ena, w_addr}), 64'd0);
    @(negedge clock); reset = 1'b0;

    // non-memory op: one-cycle latency, no bus activity
    drv_tx = mk(1'b0, 1'b0, 3'd0, 3'd0, 32'h8000_0000, 64'd0, 64'h1234); drv_have = 1;
    step(); step();
    chk("t1_wb_valid", 64'(wb_valid), 64'd1);
    chk("t1_w_data", w_data, 64'h1234);
    chk("t1_no_req", 64'(dbus_req), 64'd0);

    // LB / LBU at byte offset 3
    set_word(0, 64'h0000_0000_8000_0000);
    for (int k = 0; k < 2; k++) begin
      drv_tx = mk(1'b1, 1'b0, (k == 0) ? 3'd0 : 3'd4, 3'd0, 32'h8000_0003, 64'd0, 64'd0);
      drv_have = 1; step(); saw_addr = '0;
      for (int i = 0; i < 20 && !wb_valid; i++) begin step(); if (dbus_req) saw_addr = dbus_addr; end
      chk("t2_dbus_addr", 64'(saw_addr), 64'h8000_0000);
      chk(k == 0 ? "t2_lb" : "t2_lbu", w_data, (k == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h80);
    end

    // SH / SW at offset 6, upper strobes truncated
    for (int k = 0; k < 2; k++) begin
      drv_tx = mk(1'b1, 1'b1, 3'd0, (k == 0) ? 3'd1 : 3'd2, 32'h8000_0006, 64'hABCD, 64'h55);
      drv_have = 1; step(); step();
      chk("t3_wstrb", 64'(dbus_wstrb), 64'hC0);
      chk("t3_wdata", dbus_wdata, 64'hABCD_0000_0000_0000);
      chk("t3_we", 64'(dbus_we), 64'd1);
      wait_wb("t3_wb_timeout");
    end

    // slow grant and response
    gnt_dly = 3; rv_dly = 1;
    drv_tx = mk(1'b1, 1'b0, 3'd3, 3'd0, 32'h8000_0010, 64'd0, 64'd0); drv_have = 1;
    step(); req_cnt = 0;
    for (int i = 0; i < 20 && !wb_valid; i++) begin
      step();
      if (dbus_req) begin req_cnt++; chk("t4_ex_rdy", 64'(to_ex_ready), 64'd0); end
    end
    chk("t4_req_cycles", 64'(req_cnt), 64'd4);
    chk("t4_wb_valid", 64'(wb_valid), 64'd1);

    // WB backpressure then back-to-back accept
    gnt_dly = 0; ready_force = 1'b0;
    drv_tx = mk(1'b0, 1'b0, 3'd0, 3'd0, 32'h8000_0000, 64'd0, 64'hAAAA_5555); drv_have = 1;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_stable", w_data, 64'hAAAA_5555);
      chk("t5_ex_rdy", 64'(to_ex_ready), 64'd0);
    end
    drv_tx = mk(1'b0, 1'b0, 3'd0, 3'd0, 32'h8000_0000, 64'd0, 64'h7777); drv_have = 1;
    ready_force = 1'b1;
    step();
    chk("t5_b2b_ready", 64'(to_ex_ready), 64'd1);
    step();
    chk("t5_next_valid", 64'(wb_valid), 64'd1);
    chk("t5_next_data", w_data, 64'h7777);
    step();

    // reset while waiting for the response; the late rvalid must be ignored
    rv_dly = 5;
    drv_tx = mk(1'b1, 1'b0, 3'd3, 3'd0, 32'h8000_0020, 64'd0, 64'd0); drv_have = 1;
    step(); step(); step();
    reset = 1'b1; #1;
    chk("t6_req", 64'(dbus_req), 64'd0);
    chk("t6_wb_valid", 64'(wb_valid), 64'd0);
    chk("t6_ex_rdy", 64'(to_ex_ready), 64'd0);
    chk("t6_w_data", w_data, 64'd0);
    exp_q.delete(); bus_q.delete(); rsp_state = 0; prev_hold = 0;
    step();
    reset = 1'b0; rv_inject = 1;
    step(); step();
    chk("t6_no_wb", 64'(wb_valid), 64'd0);
    chk("t6_idle", 64'(to_ex_ready), 64'd1);

    // random traffic
    ready_rand = 1; gnt_dly = -1; rv_dly = -1; ntx = 0; cyc = 0;
    while (ntx < 400 && cyc < 8000) begin
      if (!drv_have && $urandom_range(0, 3) != 0) begin drv_tx = rand_tx(); drv_have = 1; ntx++; end
      step(); cyc++;
    end
    for (int i = 0; i < 200 && (drv_have || exp_q.size() != 0); i++) step();
    chk("drain_pending", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
